// File: rtl/i2c_target_pkg.sv
// rtl/i2c_target_pkg.sv - shared types and helpers for the I2C register target
package i2c_target_pkg;

  localparam int I2C_BYTE_W = 8;
  localparam int I2C_ADDR_W = 7;

  typedef enum logic [3:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    PTR,
    PTR_ACK,
    WDATA,
    WDATA_ACK,
    RDATA,
    RDATA_ACK,
    IGNORE
  } i2c_tgt_state_e;

  function automatic logic maj3(input logic [2:0] v);
    return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
  endfunction

endpackage

// File: rtl/i2c_target_sync.sv
// rtl/i2c_target_sync.sv - SCL/SDA synchroniser, optional glitch filter (I2C_TGT_GLITCH_FILTER_EN), edge/START/STOP detect
module i2c_target_sync import i2c_target_pkg::*; #(
  parameter int SyncStages = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic scl_i,
  input  logic sda_i,
  output logic scl_rise,
  output logic scl_fall,
  output logic start,
  output logic stop,
  output logic sda_s
);

  logic [SyncStages-1:0] scl_sync_q, sda_sync_q;
  logic                  scl_lvl, sda_lvl;
  logic                  scl_q, sda_q;

  // Idle bus is high, so flops come out of reset high to avoid a phantom edge
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
    end else begin
      scl_sync_q <= {scl_sync_q[SyncStages-2:0], scl_i};
      sda_sync_q <= {sda_sync_q[SyncStages-2:0], sda_i};
    end
  end

`ifdef I2C_TGT_GLITCH_FILTER_EN
  logic [2:0] scl_flt_q, sda_flt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      scl_flt_q <= '1;
      sda_flt_q <= '1;
    end else begin
      scl_flt_q <= {scl_flt_q[1:0], scl_sync_q[SyncStages-1]};
      sda_flt_q <= {sda_flt_q[1:0], sda_sync_q[SyncStages-1]};
    end
  end

  assign scl_lvl = maj3(scl_flt_q);
  assign sda_lvl = maj3(sda_flt_q);
`else
  assign scl_lvl = scl_sync_q[SyncStages-1];
  assign sda_lvl = sda_sync_q[SyncStages-1];
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      scl_q <= 1'b1;
      sda_q <= 1'b1;
    end else begin
      scl_q <= scl_lvl;
      sda_q <= sda_lvl;
    end
  end

  assign scl_rise = scl_lvl & ~scl_q;
  assign scl_fall = ~scl_lvl & scl_q;
  assign start    = scl_lvl & scl_q & sda_q & ~sda_lvl;
  assign stop     = scl_lvl & scl_q & ~sda_q & sda_lvl;
  assign sda_s    = sda_lvl;

endmodule

// File: rtl/i2c_target_regs.sv
// rtl/i2c_target_regs.sv - I2C target with byte register file; glitch filter via I2C_TGT_GLITCH_FILTER_EN
module i2c_target_regs import i2c_target_pkg::*; #(
  parameter logic [I2C_ADDR_W-1:0] TargetAddr = 7'h50,
  parameter int                    NumRegs    = 16,
  parameter int                    SyncStages = 2
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       scl_i,
  input  logic                       sda_i,
  output logic                       sda_oe_o,
  input  logic [$clog2(NumRegs)-1:0] reg_idx_i,
  output logic [I2C_BYTE_W-1:0]      reg_rdata_o,
  output logic                       wr_valid_o,
  output logic [$clog2(NumRegs)-1:0] wr_idx_o,
  output logic [I2C_BYTE_W-1:0]      wr_data_o,
  output logic                       busy_o
);

  localparam int IdxW = $clog2(NumRegs);

  i2c_tgt_state_e        state_q, state_d;
  logic                  scl_rise, scl_fall, start, stop, sda_s;
  logic [I2C_BYTE_W-1:0] shift_q, tx_q, tx_src, cur_byte;
  logic [I2C_BYTE_W-1:0] regs_q [NumRegs];
  logic [3:0]            cnt_q;
  logic [IdxW-1:0]       ptr_q, ptr_nxt, wr_idx_q;
  logic [I2C_BYTE_W-1:0] wr_data_q;
  logic                  sda_oe_q, busy_q, wr_valid_q;
  logic                  shift_en, cnt_clr, cnt_inc, ptr_ld, ptr_inc, wr_en, tx_ld, tx_next;
  logic                  sda_oe_d, busy_d, byte_done, addr_match;
  logic [2:0]            bit_sel;

  i2c_target_sync #(.SyncStages(SyncStages)) u_sync (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .scl_i    (scl_i),
    .sda_i    (sda_i),
    .scl_rise (scl_rise),
    .scl_fall (scl_fall),
    .start    (start),
    .stop     (stop),
    .sda_s    (sda_s)
  );

  assign byte_done  = scl_fall && (cnt_q == 4'd8);
  assign addr_match = (shift_q[7:1] == TargetAddr);
  assign ptr_nxt    = ptr_q + IdxW'(1);
  assign cur_byte   = regs_q[ptr_q];
  assign tx_src     = regs_q[tx_next ? ptr_nxt : ptr_q];
  assign bit_sel    = 3'd7 - cnt_q[2:0];

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // START outranks STOP and any SCL edge seen in the same cycle
  always_comb begin
    state_d = state_q;
    if (start) begin
      state_d = ADDR;
    end else if (stop) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        ADDR:      if (byte_done) state_d = addr_match ? ADDR_ACK : IGNORE;
        ADDR_ACK:  if (scl_fall)  state_d = shift_q[0] ? RDATA : PTR;
        PTR:       if (byte_done) state_d = PTR_ACK;
        PTR_ACK:   if (scl_fall)  state_d = WDATA;
        WDATA:     if (byte_done) state_d = WDATA_ACK;
        WDATA_ACK: if (scl_fall)  state_d = WDATA;
        RDATA:     if (byte_done) state_d = RDATA_ACK;
        RDATA_ACK: if (scl_rise)  state_d = sda_s ? IGNORE : RDATA;
        default:   state_d = state_q;
      endcase
    end
  end

  always_comb begin
    shift_en = 1'b0;
    cnt_clr  = 1'b0;
    cnt_inc  = 1'b0;
    ptr_ld   = 1'b0;
    ptr_inc  = 1'b0;
    wr_en    = 1'b0;
    tx_ld    = 1'b0;
    tx_next  = 1'b0;
    sda_oe_d = sda_oe_q;
    busy_d   = busy_q;
    if (start) begin
      cnt_clr  = 1'b1;
      sda_oe_d = 1'b0;
      busy_d   = 1'b1;
    end else if (stop) begin
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
    end else begin
      unique case (state_q)
        ADDR, PTR, WDATA: begin
          if (scl_rise) begin
            shift_en = 1'b1;
            cnt_inc  = 1'b1;
          end
          if (byte_done) begin
            sda_oe_d = (state_q == ADDR) ? addr_match : 1'b1;
            ptr_ld   = (state_q == PTR);
            wr_en    = (state_q == WDATA);
          end
        end
        ADDR_ACK: if (scl_fall) begin
          cnt_clr  = 1'b1;
          tx_ld    = shift_q[0];
          sda_oe_d = shift_q[0] & ~cur_byte[7];
        end
        PTR_ACK, WDATA_ACK: if (scl_fall) begin
          cnt_clr  = 1'b1;
          sda_oe_d = 1'b0;
        end
        RDATA: begin
          if (scl_rise) cnt_inc = 1'b1;
          if (scl_fall) sda_oe_d = cnt_q[3] ? 1'b0 : ~tx_q[bit_sel];
        end
        // Pointer advances past every byte read; only an ACK fetches the next one
        RDATA_ACK: if (scl_rise) begin
          ptr_inc = 1'b1;
          tx_ld   = ~sda_s;
          tx_next = 1'b1;
          cnt_clr = 1'b1;
        end
        default: sda_oe_d = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sda_oe_q   <= 1'b0;
      busy_q     <= 1'b0;
      wr_valid_q <= 1'b0;
      wr_idx_q   <= '0;
      wr_data_q  <= '0;
      cnt_q      <= '0;
      shift_q    <= '0;
      tx_q       <= '0;
      ptr_q      <= '0;
      for (int i = 0; i < NumRegs; i++) regs_q[i] <= '0;
    end else begin
      sda_oe_q   <= sda_oe_d;
      busy_q     <= busy_d;
      wr_valid_q <= wr_en;
      if (cnt_clr)      cnt_q <= '0;
      else if (cnt_inc) cnt_q <= cnt_q + 4'd1;
      if (shift_en) shift_q <= {shift_q[6:0], sda_s};
      if (tx_ld)    tx_q    <= tx_src;
      if (ptr_ld)                ptr_q <= shift_q[IdxW-1:0];
      else if (ptr_inc || wr_en) ptr_q <= ptr_nxt;
      if (wr_en) begin
        regs_q[ptr_q] <= shift_q;
        wr_idx_q      <= ptr_q;
        wr_data_q     <= shift_q;
      end
    end
  end

  assign sda_oe_o    = sda_oe_q;
  assign busy_o      = busy_q;
  assign wr_valid_o  = wr_valid_q;
  assign wr_idx_o    = wr_idx_q;
  assign wr_data_o   = wr_data_q;
  assign reg_rdata_o = regs_q[reg_idx_i];

endmodule

// File: tb/tb_i2c_target_regs.sv
// tb/tb_i2c_target_regs.sv - directed and randomized bench for i2c_target_regs against a transaction-level model
module tb_i2c_target_regs;
  import i2c_target_pkg::*;

  typedef logic [7:0] bq_t[$];

  logic       clk = 1'b0, rst = 1'b1, scl_m = 1'b1, sda_m = 1'b1;
  logic [3:0] reg_idx = '0;
  logic       sda_oe, wr_valid, busy;
  logic [3:0] wr_idx;
  logic [7:0] wr_data, reg_rdata;
  wire        sda_bus = sda_m & ~sda_oe;

  int passed = 0, total = 0;
  logic [7:0]  mregs [16];
  int          mptr;
  logic [11:0] exp_wr[$], got_wr[$];
  logic        oe_seen, busy_seen;

  always #5 clk = ~clk;

  i2c_target_regs #(.TargetAddr(7'h50), .NumRegs(16), .SyncStages(2)) dut (
    .clk_i(clk), .rst_i(rst), .scl_i(scl_m), .sda_i(sda_bus), .sda_oe_o(sda_oe),
    .reg_idx_i(reg_idx), .reg_rdata_o(reg_rdata), .wr_valid_o(wr_valid),
    .wr_idx_o(wr_idx), .wr_data_o(wr_data), .busy_o(busy)
  );

  always @(negedge clk) begin
    if (wr_valid) got_wr.push_back({wr_idx, wr_data});
    if (sda_oe) oe_seen = 1'b1;
    if (busy) busy_seen = 1'b1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bit_x(input logic b, output logic s);
    sda_m = b; clks(4);
    scl_m = 1'b1; clks(4);
    s = sda_bus; clks(4);
    scl_m = 1'b0; clks(4);
  endtask

  task automatic start_c;
    sda_m = 1'b1; clks(4); scl_m = 1'b1; clks(4);
    sda_m = 1'b0; clks(4); scl_m = 1'b0; clks(4);
  endtask

  task automatic stop_c;
    sda_m = 1'b0; clks(4); scl_m = 1'b1; clks(4); sda_m = 1'b1; clks(8);
  endtask

  task automatic wbyte(input logic [7:0] b, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) bit_x(b[i], s);
    bit_x(1'b1, s);
    ack = ~s;
  endtask

  task automatic rbyte(input logic mack, output logic [7:0] d);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      bit_x(1'b1, s);
      d[i] = s;
    end
    bit_x(~mack, s);
  endtask

  task automatic cmp_wr(input string tag);
    check({tag, "_wr_count"}, got_wr.size(), exp_wr.size());
    for (int i = 0; i < exp_wr.size() && i < got_wr.size(); i++)
      check({tag, "_wr_event"}, got_wr[i], exp_wr[i]);
    got_wr.delete();
    exp_wr.delete();
  endtask

  task automatic do_write(input string tag, input logic [7:0] p, input bq_t d);
    logic ack;
    start_c;
    check({tag, "_busy_after_start"}, busy, 1'b1);
    wbyte(8'hA0, ack); check({tag, "_addr_ack"}, ack, 1'b1);
    wbyte(p, ack);     check({tag, "_ptr_ack"}, ack, 1'b1);
    mptr = p % 16;
    foreach (d[i]) begin
      wbyte(d[i], ack); check({tag, "_data_ack"}, ack, 1'b1);
      exp_wr.push_back({4'(mptr), d[i]});
      mregs[mptr] = d[i];
      mptr = (mptr + 1) % 16;
    end
    stop_c;
    check({tag, "_busy_after_stop"}, busy, 1'b0);
    cmp_wr(tag);
  endtask

  task automatic do_read(input string tag, input logic set_ptr, input logic [7:0] p, input int n);
    logic ack;
    logic [7:0] d;
    start_c;
    if (set_ptr) begin
      wbyte(8'hA0, ack); check({tag, "_waddr_ack"}, ack, 1'b1);
      wbyte(p, ack);     check({tag, "_ptr_ack"}, ack, 1'b1);
      mptr = p % 16;
      start_c;
    end
    wbyte(8'hA1, ack); check({tag, "_raddr_ack"}, ack, 1'b1);
    for (int k = 0; k < n; k++) begin
      rbyte(k != n - 1, d);
      check({tag, "_rdata"}, d, mregs[mptr]);
      mptr = (mptr + 1) % 16;
    end
    check({tag, "_release_after_nack"}, sda_oe, 1'b0);
    stop_c;
    check({tag, "_busy_after_stop"}, busy, 1'b0);
  endtask

  task automatic dump_regs(input string tag);
    for (int i = 0; i < 16; i++) begin
      reg_idx = 4'(i);
      #1;
      check(tag, reg_rdata, mregs[i]);
    end
  endtask

  initial begin
    logic ack;
    bq_t  d;
    for (int i = 0; i < 16; i++) mregs[i] = 8'h00;
    mptr = 0;
    clks(4);
    rst = 1'b0;
    clks(4);
    check("reset_sda_oe", sda_oe, 1'b0);
    check("reset_busy", busy, 1'b0);
    check("reset_wr_valid", wr_valid, 1'b0);
    check("reset_wr_idx", wr_idx, 4'd0);
    check("reset_wr_data", wr_data, 8'd0);
    dump_regs("reset_regs");

    do_write("t1", 8'h03, {8'h11, 8'h22});
    dump_regs("t1_regs");

    do_read("t2", 1'b1, 8'h03, 2);
    do_read("t2_ptr5", 1'b0, 8'h00, 1);

    oe_seen = 1'b0;
    start_c;
    wbyte(8'hA2, ack); check("t3_addr_nack", ack, 1'b0);
    wbyte(8'h55, ack); check("t3_data_nack", ack, 1'b0);
    stop_c;
    check("t3_oe_never", oe_seen, 1'b0);
    cmp_wr("t3");

    do_write("t4", 8'h0F, {8'hAA, 8'hBB, 8'hCC});
    reg_idx = 4'd0; #1;
    check("t4_reg0", reg_rdata, 8'hBB);

    for (int t = 0; t < 8; t++) begin
      if ($urandom_range(0, 1) == 0) begin
        d.delete();
        repeat ($urandom_range(1, 3)) d.push_back(8'($urandom));
        do_write("rnd_w", 8'($urandom), d);
      end else begin
        do_read("rnd_r", 1'($urandom_range(0, 1)), 8'($urandom), $urandom_range(1, 3));
      end
    end
    dump_regs("rnd_regs");

    do_write("t5_setup", 8'h07, {8'h35});
    start_c;
    wbyte(8'hA0, ack);
    wbyte(8'h07, ack);
    start_c;
    wbyte(8'hA1, ack); check("t5_raddr_ack", ack, 1'b1);
    check("t5_driving_zero", sda_oe, 1'b1);
    rst = 1'b1;
    @(posedge clk); #1;
    check("t5_release_next_edge", sda_oe, 1'b0);
    clks(3);
    rst = 1'b0;
    sda_m = 1'b1; scl_m = 1'b1;
    clks(8);
    check("t5_busy", busy, 1'b0);
    check("t5_state_idle", dut.state_q, IDLE);
    for (int i = 0; i < 16; i++) mregs[i] = 8'h00;
    mptr = 0;
    dump_regs("t5_regs");
    got_wr.delete();
    do_read("t5_ptr0", 1'b0, 8'h00, 1);

    oe_seen = 1'b0;
    busy_seen = 1'b0;
    sda_m = 1'b0; clks(1);
    sda_m = 1'b1; clks(12);
`ifdef I2C_TGT_GLITCH_FILTER_EN
    check("t6_no_start", busy_seen, 1'b0);
`else
    check("t6_pulse_is_start", busy_seen, 1'b1);
`endif
    check("t6_busy_idle", busy, 1'b0);
    check("t6_oe_never", oe_seen, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
